// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter group: datapath widths and
// the FSM state encoding used by sll_iterative.
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SHW-1:0]   shamt_t;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/sll_iterative_if.sv
// Start/ready handshake and result bus of the iterative left shifter.
// Handshake: ctrl_start is sampled only while the unit is idle; data_resultRDY
// is a one-cycle completion pulse, and data_result/data_overflow hold until the
// next accepted start. There is no backpressure on the result side.
interface sll_iterative_if;
  import shift_pkg::*;

  logic       ctrl_start;
  word_t      data_operandA;
  shamt_t     ctrl_shiftamt;
  word_t      data_result;
  logic       data_resultRDY;
  logic       data_overflow;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    output ctrl_start, data_operandA, ctrl_shiftamt,
    input  data_result, data_resultRDY, data_overflow, busy, dbg_state
  );

  modport slave (
    input  ctrl_start, data_operandA, ctrl_shiftamt,
    output data_result, data_resultRDY, data_overflow, busy, dbg_state
  );
endinterface

// File: rtl/leftshift1.sv
// One-position logical left shift with zero fill; ctrl_i=0 passes data_i through.
module leftshift1
  import shift_pkg::*;
(
  input  word_t data_i,
  input  logic  ctrl_i,
  output word_t data_o
);

  assign data_o = ctrl_i ? {data_i[WIDTH-2:0], 1'b0} : data_i;

endmodule

// File: rtl/sll_iterative.sv
// Multi-cycle logical left shifter: one bit per clock, with a sticky flag for
// any set bit shifted out of the MSB.
module sll_iterative
  import shift_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  sll_iterative_if.slave bus
);

  localparam shamt_t CNT_ONE = shamt_t'(1);
  localparam shamt_t CNT_ZERO = '0;

  logic [1:0] state_q, state_d;
  shamt_t     count_q, count_d;
  word_t      result_q, result_d;
  word_t      shifted;
  logic       ovf_q, ovf_d;

  // Outside SHIFT the bypass feeds result_q back, so the register holds.
  leftshift1 u_leftshift1 (
    .data_i (result_q),
    .ctrl_i (state_q == ST_SHIFT),
    .data_o (shifted)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = shifted;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_start) begin
          result_d = bus.data_operandA;
          count_d  = bus.ctrl_shiftamt;
          ovf_d    = 1'b0;
          state_d  = (bus.ctrl_shiftamt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ovf_d   = ovf_q | result_q[WIDTH-1];
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_overflow  = ovf_q;
  assign bus.data_resultRDY = (state_q == ST_DONE);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.dbg_state      = state_q;

endmodule

// File: doc/sll_iterative.md
# sll_iterative

Multi-cycle logical left shifter for the ALU shifting group. It is the left-direction counterpart to the one-bit arithmetic right-shift stage. It shifts `data_operandA` left by `ctrl_shiftamt` positions, one bit per clock, behind a start/ready handshake in the style of the multdiv unit. It also reports whether any set bit was shifted out of bit 31.

## Interface
- `WIDTH`, 32: data width, fixed at 32 for the datapath.
- `SHW`, 5: shift-amount width, equal to log2(`WIDTH`).
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state and outputs immediately.
- `ctrl_start`, input, 1: start request; sampled only in IDLE.
- `data_operandA`, input, 32: value to shift; captured when the start is accepted.
- `ctrl_shiftamt`, input, 5: shift count 0–31; captured when the start is accepted.
- `data_result`, output, 32: shift register contents; final value valid when `data_resultRDY`=1 and held until the next start is accepted.
- `data_resultRDY`, output, 1: single-cycle completion pulse.
- `data_overflow`, output, 1: sticky OR of every bit shifted out of bit 31 during the current operation; valid with `data_resultRDY` and held like `data_result`.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, `ctrl_start`=1:
  - Load `data_result` <= `data_operandA`, `count` <= `ctrl_shiftamt`, `data_overflow` <= 0.
  - Next state is DONE if the shift amount is 0, otherwise SHIFT.
- IDLE, `ctrl_start`=0: hold all registers.
- SHIFT, each edge:
  - `data_result` <= {`data_result`[30:0], 1'b0}.
  - `data_overflow` <= `data_overflow` | `data_result`[31].
  - `count` <= `count` − 1.
  - If `count`==1 at this edge, next state is DONE.
- DONE: `data_resultRDY`=1 (Moore, decoded from state); next edge returns to IDLE.
- Arithmetic rules:
  - Logical shift; zeros enter at bit 0.
  - The result equals `data_operandA << ctrl_shiftamt` truncated to 32 bits.
  - `count` never underflows: SHIFT is never entered with `count`=0.
- `ctrl_start` in SHIFT or DONE is ignored. Operands are not re-sampled, and there is no queueing.
- `data_operandA` and `ctrl_shiftamt` may change freely after acceptance without affecting the run.
- Async reset (`reset`=0) at any point, including mid-SHIFT or in DONE:
  - State goes to IDLE; `data_result`, `count`, `data_overflow` go to 0; `data_resultRDY` and `busy` go to 0.
  - The aborted operation never produces a ready pulse.
- Reset values: `data_result`=0, `data_resultRDY`=0, `data_overflow`=0, `busy`=0.

## Timing
- Start accepted at edge E0 (IDLE with `ctrl_start`=1).
- For shift amount k, DONE is entered at edge Ek, where E0 is used for k=0.
  - `data_resultRDY` is high for exactly the one cycle following Ek.
- Total latency is k+1 edges from acceptance to return to IDLE. Maximum is 32 edges (k=31).
- `busy` rises in the cycle after E0 and falls in the cycle after the DONE→IDLE edge.
- Back-to-back operation: a new start is accepted on the first IDLE cycle after DONE, so there is one idle-capable cycle between ready pulses at minimum.
- No combinational path exists from inputs to outputs. All outputs are registers or state decodes.

## Structure
- A shared package `shift_pkg` holds:
  - State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. Code 2'b11 is illegal and recovers to IDLE.
  - `WIDTH`=32 and `SHW`=5.
- One sub-module, `leftshift1`: combinational one-position left shift with zero fill and a `ctrl` bypass mux (`ctrl`=0 passes the input unchanged).
  - Its bypass is driven by state==SHIFT, and it feeds the `data_result` register input.
- The top-level FSM, the down-counter, and the overflow accumulator live in `sll_iterative`.

## Test plan
- Basic shift: operand 0x0000_0001, shamt 4.
  - `data_resultRDY` pulses in the cycle after E4.
  - `data_result`=0x0000_0010, `data_overflow`=0.
- Zero shift: operand 0xDEAD_BEEF, shamt 0.
  - Ready in the cycle after E0.
  - `data_result`=0xDEAD_BEEF, `data_overflow`=0, `busy` high for exactly 1 cycle.
- Maximum shift: operand 0x8000_0001, shamt 31.
  - Ready after E31.
  - `data_result`=0x8000_0000, `data_overflow`=1.
- Start while busy: operand 0x0000_00FF, shamt 8. At E3, reassert `ctrl_start` with operand 0x1234_5678, shamt 1.
  - The second start is ignored.
  - Ready after E8 with `data_result`=0x0000_FF00; only one ready pulse.
- Reset mid-operation: operand 0x0000_0003, shamt 10; assert `reset`=0 between E3 and E4.
  - All outputs read 0 immediately; no ready pulse.
  - After release, operand 0x0000_0003, shamt 2 yields 0x0000_000C.
- Back-to-back: after the first ready pulse, assert `ctrl_start` on the first IDLE cycle with operand 0xF000_0000, shamt 2.
  - The start is accepted.
  - Ready yields `data_result`=0xC000_0000 with `data_overflow`=1, because the bit shifted out was set.
